syscall_print_unit: RTL and testbench

//  Services MIPS print syscalls at writeback: on syscall_w with v0=4 it walks the
//  NUL-terminated string at byte address a0 through the data memory read port and

---
 rtl/syscall_print_unit.sv | 172 +++++++++++++++++
 tb/tb_syscall_print_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_print_unit.sv
// Console service for the MIPS print-string, print-char and exit syscalls.
// Fetches string bytes from the data memory word read port and emits one character per handshake.
module syscall_print_unit #(
  parameter int MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_w,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        stall,
  output logic        done,
  output logic        trunc,
  output logic        halted
);

  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_HALT
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   ptr, ptr_nx;
  logic [CW-1:0] count, count_nx;
  logic [CW-1:0] count_inc;
  logic [7:0]    char_q, char_nx;
  logic          trunc_q, trunc_nx;
  logic          halted_q, halted_nx;
  logic          single_q, single_nx;
  logic [7:0]    fetch_byte;

  assign char_out  = char_q;
  assign trunc     = trunc_q;
  assign halted    = halted_q;
  assign count_inc = count + CW'(1);

  // Little-endian lane select: byte offset 0 lives in bits [7:0].
  always_comb begin
    fetch_byte = mem_rd[7:0];
    case (ptr[1:0])
      2'd0: fetch_byte = mem_rd[7:0];
      2'd1: fetch_byte = mem_rd[15:8];
      2'd2: fetch_byte = mem_rd[23:16];
      2'd3: fetch_byte = mem_rd[31:24];
      default: fetch_byte = mem_rd[7:0];
    endcase
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case so no path infers a latch.
    state_nx   = state;
    ptr_nx     = ptr;
    count_nx   = count;
    char_nx    = char_q;
    trunc_nx   = trunc_q;
    halted_nx  = halted_q;
    single_nx  = single_q;
    mem_addr   = 32'd0;
    char_valid = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (syscall_w && !halted_q) begin
          case (v0)
            SYS_PRINT_STR: begin
              ptr_nx    = a0;
              count_nx  = '0;
              trunc_nx  = 1'b0;
              single_nx = 1'b0;
              stall     = 1'b1;
              state_nx  = S_FETCH;
            end
            SYS_PRINT_CHAR: begin
              char_nx   = a0[7:0];
              trunc_nx  = 1'b0;
              single_nx = 1'b1;
              stall     = 1'b1;
              state_nx  = S_EMIT;
            end
            SYS_EXIT: begin
              // Completes in this cycle, so stall stays low and the syscall retires once.
              halted_nx = 1'b1;
              done      = 1'b1;
              state_nx  = S_HALT;
            end
            default: ;
          endcase
        end
      end

      S_FETCH: begin
        mem_addr = {ptr[31:2], 2'b00};
        char_nx  = fetch_byte;
        if (fetch_byte == 8'd0) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          stall    = 1'b1;
          state_nx = S_EMIT;
        end
      end

      S_EMIT: begin
        char_valid = 1'b1;
        stall      = 1'b1;
        if (char_ready) begin
          if (single_q) begin
            done     = 1'b1;
            stall    = 1'b0;
            state_nx = S_IDLE;
          end else begin
            ptr_nx   = ptr + 32'd1;
            count_nx = count_inc;
            if (count_inc == CW'(MAX_LEN)) begin
              trunc_nx = 1'b1;
              done     = 1'b1;
              stall    = 1'b0;
              state_nx = S_IDLE;
            end else begin
              state_nx = S_FETCH;
            end
          end
        end
      end

      S_HALT: begin
        stall = 1'b1;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= 32'd0;
      count    <= '0;
      char_q   <= 8'd0;
      trunc_q  <= 1'b0;
      halted_q <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      count    <= count_nx;
      char_q   <= char_nx;
      trunc_q  <= trunc_nx;
      halted_q <= halted_nx;
      single_q <= single_nx;
    end
  end

endmodule

// File: tb/tb_syscall_print_unit.sv
// Scoreboard bench for syscall_print_unit: stimulus queues expected chars and fetch addresses,
// a negedge monitor pops and compares on every handshake and every memory read.
module tb_syscall_print_unit;

  localparam int TB_MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        syscall_w = 1'b0;
  logic [31:0] v0 = 32'd0;
  logic [31:0] a0 = 32'd0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        stall;
  logic        done;
  logic        trunc;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_chars[$];
  logic [31:0] exp_addrs[$];
  logic [7:0]  mem [logic [31:0]];

  syscall_print_unit #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .syscall_w  (syscall_w),
    .v0         (v0),
    .a0         (a0),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .stall      (stall),
    .done       (done),
    .trunc      (trunc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'd0;
  endfunction

  always_comb begin
    mem_rd = {rd_byte(mem_addr + 32'd3), rd_byte(mem_addr + 32'd2),
              rd_byte(mem_addr + 32'd1), rd_byte(mem_addr)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each accepted character and each word fetch.
  always @(negedge clk) begin
    if (!reset) begin
      if (char_valid && char_ready) begin
        if (exp_chars.size() == 0) check("unexpected_char", {24'd0, char_out}, 32'hFFFF_FFFF);
        else check("char", {24'd0, char_out}, {24'd0, exp_chars.pop_front()});
      end
      if (mem_addr != 32'd0) begin
        if (exp_addrs.size() == 0) check("unexpected_fetch", mem_addr, 32'hFFFF_FFFF);
        else check("fetch_addr", mem_addr, exp_addrs.pop_front());
      end
    end
  end

  task automatic put_str(input logic [31:0] a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + 32'(i)] = s[i];
    mem[a + 32'(s.len())] = 8'd0;
  endtask

  task automatic push_fetches(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = a + 32'(i);
      exp_addrs.push_back({p[31:2], 2'b00});
    end
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    @(posedge clk);
    #1;
    syscall_w = 1'b1;
    v0        = code;
    a0        = arg;
  endtask

  task automatic release_syscall();
    @(posedge clk);
    #1;
    syscall_w = 1'b0;
    v0        = 32'd0;
    a0        = 32'd0;
  endtask

  // Counts cycles from the issue cycle to the done cycle; stall must be high on every earlier cycle.
  task automatic wait_done(input string name, output int cyc);
    bit stall_ok;
    bit seen;
    stall_ok = 1'b1;
    seen     = 1'b0;
    cyc      = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({name, "_stall_at_done"}, {31'd0, stall}, 32'd0);
        break;
      end
      if (!stall) stall_ok = 1'b0;
      cyc++;
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (char_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_valid_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Print-string with char_ready held high; truncated strings stop after TB_MAX_LEN chars.
  task automatic string_case(input string name, input logic [31:0] a, input string s,
                             input bit exp_trunc);
    int n_emit;
    int lat;
    n_emit = exp_trunc ? TB_MAX_LEN : s.len();
    for (int i = 0; i < n_emit; i++) exp_chars.push_back(s[i]);
    push_fetches(a, exp_trunc ? TB_MAX_LEN : s.len() + 1);
    issue(32'd4, a);
    wait_done(name, lat);
    check({name, "_latency"}, 32'(lat), exp_trunc ? 32'(2 * TB_MAX_LEN) : 32'(2 * s.len() + 1));
    release_syscall();
    @(negedge clk);
    check({name, "_trunc"}, {31'd0, trunc}, {31'd0, exp_trunc});
    check({name, "_chars_left"}, 32'(exp_chars.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    syscall_w = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat;

    put_str(32'h1001_0000, "Hi");
    mem[32'h1001_0100] = "x";
    mem[32'h1001_0101] = "y";
    mem[32'h1001_0102] = "z";
    put_str(32'h1001_0103, "AB");
    mem[32'h1001_0106] = "q";
    put_str(32'h1001_0200, "ABCDEFG");
    put_str(32'h1001_0300, "ABC");
    put_str(32'h1001_0400, "XY");
    put_str(32'h1001_0500, "");

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_char_out",   {24'd0, char_out},   32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_trunc",      {31'd0, trunc},      32'd0);
    check("rst_halted",     {31'd0, halted},     32'd0);
    check("rst_stall",      {31'd0, stall},      32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);

    string_case("hi",      32'h1001_0000, "Hi",      1'b0);
    string_case("unalign", 32'h1001_0103, "AB",      1'b0);
    string_case("empty",   32'h1001_0500, "",        1'b0);
    string_case("len3",    32'h1001_0300, "ABC",     1'b0);
    string_case("trunc",   32'h1001_0200, "ABCDEFG", 1'b1);

    // Back-pressure: char held stable, no fetch while waiting.
    exp_chars.push_back("H");
    exp_chars.push_back("i");
    push_fetches(32'h1001_0000, 3);
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    issue(32'd4, 32'h1001_0000);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", {31'd0, char_valid}, 32'd1);
      check("bp_char",  {24'd0, char_out},   32'h48);
      check("bp_noaddr", mem_addr,           32'd0);
    end
    @(posedge clk);
    #1;
    char_ready = 1'b1;
    wait_done("bp", lat);
    release_syscall();
    @(negedge clk);
    check("bp_trunc_cleared", {31'd0, trunc}, 32'd0);

    // Print-char, then an unsupported code.
    exp_chars.push_back("A");
    issue(32'd11, 32'h0000_0141);
    wait_done("pchar", lat);
    check("pchar_latency", 32'(lat), 32'd1);
    release_syscall();
    issue(32'd7, 32'h1001_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignored_stall", {31'd0, stall},      32'd0);
      check("ignored_done",  {31'd0, done},       32'd0);
      check("ignored_valid", {31'd0, char_valid}, 32'd0);
    end
    release_syscall();

    // Abort by reset while the second char waits for ready.
    exp_chars.push_back("X");
    push_fetches(32'h1001_0400, 2);
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    issue(32'd4, 32'h1001_0400);
    wait_valid("abort_x");
    @(posedge clk);
    #1;
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    wait_valid("abort_y");
    check("abort_y_char", {24'd0, char_out}, 32'h59);
    do_reset();
    @(negedge clk);
    check("abort_valid", {31'd0, char_valid}, 32'd0);
    check("abort_stall", {31'd0, stall},      32'd0);
    check("abort_char_out", {24'd0, char_out}, 32'd0);
    check("abort_chars_left", 32'(exp_chars.size()), 32'd0);
    check("abort_addrs_left", 32'(exp_addrs.size()), 32'd0);
    char_ready = 1'b1;

    // Exit: sticky halt until reset.
    issue(32'd10, 32'd0);
    wait_done("exit", lat);
    check("exit_latency", 32'(lat), 32'd0);
    release_syscall();
    issue(32'd11, 32'h0000_005A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_stall",  {31'd0, stall},      32'd1);
      check("halt_flag",   {31'd0, halted},     32'd1);
      check("halt_valid",  {31'd0, char_valid}, 32'd0);
      check("halt_done",   {31'd0, done},       32'd0);
    end
    release_syscall();
    do_reset();
    @(negedge clk);
    check("unhalt_flag",  {31'd0, halted}, 32'd0);
    check("unhalt_stall", {31'd0, stall},  32'd0);

    check("final_chars_left", 32'(exp_chars.size()), 32'd0);
    check("final_addrs_left", 32'(exp_addrs.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
